// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
// A buffered write is a destination register index plus its result data.
package regfile_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 2;
   localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] rf_reg;
      logic [DATA_WIDTH-1:0] data;
   } wb_entry_t;

   localparam logic GNT_S0 = 1'b0;
   localparam logic GNT_S1 = 1'b1;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_WIDTH-1:0] r);
      logic [NUM_REGS-1:0] v;
      v    = '0;
      v[r] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of pending register writes.
// Also reports which registers are targeted by the entries it currently holds.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  wb_entry_t           din,
   output logic                full,
   output logic                empty,
   output wb_entry_t           head,
   output logic [NUM_REGS-1:0] valid_regs
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [PW-1:0] offs;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr] <= din;
   end

   always_comb begin
      valid_regs = '0;
      offs       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PW'(i) - rd_ptr;
         if ({1'b0, offs} < count) valid_regs[mem[i].rf_reg] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Drains two buffered producers (ALU, load/mem) round-robin into the single RF write port
// and publishes a per-register pending vector for issue-stage stalling.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s0_valid,
   output logic                  s0_ready,
   input  logic [ADDR_WIDTH-1:0] s0_reg,
   input  logic [DATA_WIDTH-1:0] s0_data,
   input  logic                  s1_valid,
   output logic                  s1_ready,
   input  logic [ADDR_WIDTH-1:0] s1_reg,
   input  logic [DATA_WIDTH-1:0] s1_data,
   output logic [ADDR_WIDTH-1:0] writeRegister,
   output logic                  writeEnable,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic [NUM_REGS-1:0]   pending,
   output logic                  idle
);

   wb_entry_t             head0, head1, gnt_head;
   logic                  full0, full1, empty0, empty1;
   logic [NUM_REGS-1:0]   vregs0, vregs1;
   logic                  gnt_vld;
   logic                  gnt_sel;
   logic                  last_grant;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
      .clk        (clk),
      .rst        (rst),
      .push       (s0_valid),
      .pop        (gnt_vld && (gnt_sel == GNT_S0)),
      .din        ('{rf_reg: s0_reg, data: s0_data}),
      .full       (full0),
      .empty      (empty0),
      .head       (head0),
      .valid_regs (vregs0)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
      .clk        (clk),
      .rst        (rst),
      .push       (s1_valid),
      .pop        (gnt_vld && (gnt_sel == GNT_S1)),
      .din        ('{rf_reg: s1_reg, data: s1_data}),
      .full       (full1),
      .empty      (empty1),
      .head       (head1),
      .valid_regs (vregs1)
   );

   // Ready comes from occupancy only, so no valid->ready path exists.
   assign s0_ready = !full0;
   assign s1_ready = !full1;

   always_comb begin
      gnt_vld = !empty0 || !empty1;
      gnt_sel = GNT_S0;
      if (!empty0 && !empty1) begin
         gnt_sel = (last_grant == GNT_S0) ? GNT_S1 : GNT_S0;
      end else if (!empty1) begin
         gnt_sel = GNT_S1;
      end
   end

   assign gnt_head = (gnt_sel == GNT_S0) ? head0 : head1;

   always_ff @(posedge clk) begin
      if (rst) begin
         writeEnable   <= 1'b0;
         writeRegister <= '0;
         writeData     <= '0;
         last_grant    <= GNT_S1;
      end else begin
         writeEnable <= gnt_vld;
         if (gnt_vld) begin
            writeRegister <= gnt_head.rf_reg;
            writeData     <= gnt_head.data;
            last_grant    <= gnt_sel;
         end
      end
   end

   assign pending = vregs0 | vregs1 | (writeEnable ? reg_onehot(writeRegister) : '0);
   assign idle    = empty0 && empty1 && !writeEnable;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_regfile_write_arbiter;

   localparam int DEPTH = 2;

   logic        clk, rst;
   logic        s0_valid, s0_ready, s1_valid, s1_ready;
   logic [1:0]  s0_reg, s1_reg;
   logic [15:0] s0_data, s1_data;
   logic [1:0]  writeRegister;
   logic        writeEnable;
   logic [15:0] writeData;
   logic [3:0]  pending;
   logic        idle;

   regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .s0_valid      (s0_valid),
      .s0_ready      (s0_ready),
      .s0_reg        (s0_reg),
      .s0_data       (s0_data),
      .s1_valid      (s1_valid),
      .s1_ready      (s1_ready),
      .s1_reg        (s1_reg),
      .s1_data       (s1_data),
      .writeRegister (writeRegister),
      .writeEnable   (writeEnable),
      .writeData     (writeData),
      .pending       (pending),
      .idle          (idle)
   );

   typedef struct packed {
      logic [1:0]  r;
      logic [15:0] d;
   } ent_t;

   ent_t        q0[$], q1[$];
   logic        m_we;
   logic [1:0]  m_wr;
   logic [15:0] m_wd;
   bit          m_last;
   logic [15:0] m_rf [4];
   int          n0_acc = 0, n1_acc = 0;
   int          checks = 0, errors = 0;
   bit          chk_en = 0, sat_mon = 0, seen_nr0 = 0, seen_nr1 = 0;
   logic [17:0] dut_log[$];
   int          n0s, n1s, alt_bad, ord_bad, e0, e1;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_pending();
      logic [3:0] p = '0;
      foreach (q0[i]) p[q0[i].r] = 1'b1;
      foreach (q1[i]) p[q1[i].r] = 1'b1;
      if (m_we) p[m_wr] = 1'b1;
      return p;
   endfunction

   // Reference model: two bounded queues, round-robin pick, one registered write slot.
   always @(posedge clk) begin
      ent_t e;
      bit   rdy0, rdy1;
      int   g;
      if (m_we === 1'b1) m_rf[m_wr] = m_wd;
      if (rst) begin
         q0.delete();
         q1.delete();
         m_we = 0; m_wr = 0; m_wd = 0; m_last = 1;
      end else begin
         rdy0 = q0.size() < DEPTH;
         rdy1 = q1.size() < DEPTH;
         g = -1;
         if (q0.size() > 0 && q1.size() > 0) g = m_last ? 0 : 1;
         else if (q0.size() > 0) g = 0;
         else if (q1.size() > 0) g = 1;
         m_we = (g >= 0);
         if (g == 0) begin
            e = q0.pop_front(); m_wr = e.r; m_wd = e.d; m_last = 0;
         end else if (g == 1) begin
            e = q1.pop_front(); m_wr = e.r; m_wd = e.d; m_last = 1;
         end
         if (s0_valid && rdy0) begin q0.push_back('{s0_reg, s0_data}); n0_acc++; end
         if (s1_valid && rdy1) begin q1.push_back('{s1_reg, s1_data}); n1_acc++; end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("s0_ready", 32'(s0_ready), 32'(q0.size() < DEPTH));
         check("s1_ready", 32'(s1_ready), 32'(q1.size() < DEPTH));
         check("writeEnable", 32'(writeEnable), 32'(m_we));
         check("writeRegister", 32'(writeRegister), 32'(m_wr));
         check("writeData", 32'(writeData), 32'(m_wd));
         check("pending", 32'(pending), 32'(model_pending()));
         check("idle", 32'(idle), 32'(q0.size() == 0 && q1.size() == 0 && !m_we));
         if (writeEnable === 1'b1) dut_log.push_back({writeRegister, writeData});
         if (sat_mon && s0_ready === 1'b0) seen_nr0 = 1;
         if (sat_mon && s1_ready === 1'b0) seen_nr1 = 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Producers hold their current item until the model records it as accepted.
   task automatic drive(input bit v0, input bit v1);
      s0_valid = v0; s0_reg = 2'(n0_acc);     s0_data = {1'b0, 15'(n0_acc)};
      s1_valid = v1; s1_reg = 2'(n1_acc + 1); s1_data = {1'b1, 15'(n1_acc)};
   endtask

   initial begin
      rst = 1; s0_valid = 1; s0_reg = 1; s0_data = 16'hdead;
      s1_valid = 0; s1_reg = 0; s1_data = 0;
      step();
      chk_en = 1;
      step();
      check("rst_we", 32'(writeEnable), 32'd0);
      check("rst_wreg", 32'(writeRegister), 32'd0);
      check("rst_wdata", 32'(writeData), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_s0_ready", 32'(s0_ready), 32'd1);
      rst = 0; s0_valid = 0;
      step();
      check("rst_nothing_accepted", 32'(idle), 32'd1);

      // single write
      s0_valid = 1; s0_reg = 2; s0_data = 16'h1234;
      step();
      s0_valid = 0;
      check("t2_pending_k", 32'(pending), 32'h4);
      check("t2_we_k", 32'(writeEnable), 32'd0);
      step();
      check("t2_we", 32'(writeEnable), 32'd1);
      check("t2_wreg", 32'(writeRegister), 32'd2);
      check("t2_wdata", 32'(writeData), 32'h1234);
      check("t2_pending_k1", 32'(pending), 32'h4);
      step();
      check("t2_we_off", 32'(writeEnable), 32'd0);
      check("t2_pending_off", 32'(pending), 32'd0);
      check("t2_rf_reg2", 32'(m_rf[2]), 32'h1234);

      // tie after reset: s0 first
      rst = 1; step(); rst = 0;
      s0_valid = 1; s0_reg = 1; s0_data = 16'hAAAA;
      s1_valid = 1; s1_reg = 3; s1_data = 16'h5555;
      step();
      s0_valid = 0; s1_valid = 0;
      step();
      check("t3_first_reg", 32'(writeRegister), 32'd1);
      check("t3_first_data", 32'(writeData), 32'hAAAA);
      check("t3_first_we", 32'(writeEnable), 32'd1);
      step();
      check("t3_second_reg", 32'(writeRegister), 32'd3);
      check("t3_second_data", 32'(writeData), 32'h5555);
      check("t3_second_we", 32'(writeEnable), 32'd1);
      step();
      check("t3_done_we", 32'(writeEnable), 32'd0);

      // saturation
      rst = 1; step(); rst = 0;
      n0s = n0_acc; n1s = n1_acc;
      dut_log.delete();
      seen_nr0 = 0; seen_nr1 = 0; sat_mon = 1;
      repeat (10) begin drive(1, 1); step(); end
      drive(0, 0);
      repeat (8) step();
      sat_mon = 0;
      alt_bad = 0; ord_bad = 0; e0 = n0s; e1 = n1s;
      foreach (dut_log[i]) begin
         if (i > 0 && dut_log[i][15] == dut_log[i-1][15]) alt_bad++;
         if (dut_log[i][15] == 1'b0) begin
            if (dut_log[i][14:0] != 15'(e0)) ord_bad++;
            e0++;
         end else begin
            if (dut_log[i][14:0] != 15'(e1)) ord_bad++;
            e1++;
         end
      end
      check("t4_accepted", 32'((n0_acc - n0s) + (n1_acc - n1s)), 32'd12);
      check("t4_writes", 32'(dut_log.size()), 32'd12);
      check("t4_alternate", 32'(alt_bad), 32'd0);
      check("t4_order", 32'(ord_bad), 32'd0);
      check("t4_s0_ready_low", 32'(seen_nr0), 32'd1);
      check("t4_s1_ready_low", 32'(seen_nr1), 32'd1);

      // full FIFO0 while s1 holds priority, then popped
      rst = 1; step(); rst = 0;
      drive(1, 1); step();
      drive(1, 0); step();
      drive(1, 0); step();
      check("t5_ready_pop_cycle", 32'(s0_ready), 32'd0);
      drive(1, 0); step();
      check("t5_ready_after", 32'(s0_ready), 32'd1);
      drive(0, 0);
      repeat (4) step();

      // reset mid-operation
      rst = 1; step(); rst = 0;
      repeat (6) begin drive(1, 1); step(); end
      check("t6_busy", 32'(pending != 4'd0), 32'd1);
      rst = 1; step();
      check("t6_we", 32'(writeEnable), 32'd0);
      check("t6_pending", 32'(pending), 32'd0);
      check("t6_idle", 32'(idle), 32'd1);
      rst = 0; drive(0, 0);
      dut_log.delete();
      repeat (5) step();
      check("t6_no_writes", 32'(dut_log.size()), 32'd0);

      // randomized traffic with sporadic resets
      for (int c = 0; c < 3000; c++) begin
         int dens;
         dens = (c / 500) % 3;
         rst      = ($urandom_range(0, 199) == 0);
         s0_valid = ($urandom_range(0, 3) < 32'(dens + 1));
         s1_valid = ($urandom_range(0, 3) < 32'(dens + 1));
         s0_reg   = 2'($urandom);
         s1_reg   = 2'($urandom);
         s0_data  = 16'($urandom);
         s1_data  = 16'($urandom);
         step();
      end
      rst = 0; s0_valid = 0; s1_valid = 0;
      repeat (6) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
